// File: rtl/bcd_disp_pkg.sv
// Shared constants and types for the 3-digit BCD display scanner.
package bcd_disp_pkg;

    localparam int unsigned NUM_DIGITS = 3;

    typedef logic [1:0] digit_idx_t;

    localparam digit_idx_t LAST_IDX = digit_idx_t'(NUM_DIGITS - 1);

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low one-cold digit enable for a given scan index
    function automatic logic [NUM_DIGITS-1:0] digit_enable(input digit_idx_t idx);
        logic [NUM_DIGITS-1:0] one;
        one = {{(NUM_DIGITS-1){1'b0}}, 1'b1};
        return ~(one << idx);
    endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD nibble to active-low 7-segment decoder with blank override.
module bcd_to_seg
    import bcd_disp_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        if (blank) begin
            seg = SEG_BLANK;
        end else begin
            case (nibble)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// Multiplexed 3-digit common-anode 7-segment driver; new BCD values take effect
// only at frame boundaries so a single scan frame never mixes two values.
module bcd_display_scanner
    import bcd_disp_pkg::*;
#(
    parameter int unsigned DIV = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] bcd,
    input  logic        bcd_valid,
    input  logic        blank_en,
    output logic [6:0]  seg,
    output logic [2:0]  an,
    output logic        frame_tick
);

    localparam int unsigned CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] presc_q, presc_d;
    digit_idx_t       idx_q, idx_d;
    logic [11:0]      shadow_q, active_q;
    logic             pending_q;
    logic [6:0]       seg_q, seg_d;
    logic [2:0]       an_q, an_d;
    logic             tick_q;

    logic             last_cnt;
    logic             boundary;
    logic [3:0]       nibble;
    logic             blank;
    logic             hund_zero;
    logic             tens_zero;

    assign last_cnt = (presc_q == CNT_LAST);
    assign boundary = last_cnt && (idx_q == LAST_IDX);

    always_comb begin
        presc_d = presc_q + CNT_W'(1);
        idx_d   = idx_q;
        if (last_cnt) begin
            presc_d = '0;
            idx_d   = (idx_q == LAST_IDX) ? digit_idx_t'(0) : idx_q + digit_idx_t'(1);
        end
    end

    // Leading-zero blanking only ever looks at decimal zeros; A-F never blanks.
    assign hund_zero = (active_q[11:8] == 4'd0);
    assign tens_zero = (active_q[7:4] == 4'd0);

    always_comb begin
        nibble = active_q[3:0];
        blank  = 1'b0;
        case (idx_q)
            2'd1: begin
                nibble = active_q[7:4];
                blank  = blank_en && hund_zero && tens_zero;
            end
            2'd2: begin
                nibble = active_q[11:8];
                blank  = blank_en && hund_zero;
            end
            default: begin
                nibble = active_q[3:0];
                blank  = 1'b0;
            end
        endcase
        an_d = digit_enable(idx_q);
    end

    bcd_to_seg u_bcd_to_seg (
        .nibble (nibble),
        .blank  (blank),
        .seg    (seg_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q   <= '0;
            idx_q     <= '0;
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
            seg_q     <= SEG_BLANK;
            an_q      <= 3'b111;
            tick_q    <= 1'b0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            tick_q  <= boundary;
            seg_q   <= seg_d;
            an_q    <= an_d;
            if (bcd_valid) begin
                shadow_q <= bcd;
            end
            // A strobe landing on the boundary bypasses the shadow register.
            if (boundary) begin
                pending_q <= 1'b0;
                if (bcd_valid) begin
                    active_q <= bcd;
                end else if (pending_q) begin
                    active_q <= shadow_q;
                end
            end else if (bcd_valid) begin
                pending_q <= 1'b1;
            end
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_tick = tick_q;

endmodule
